arbitro_memdados: RTL and testbench

Two-port arbiter and sequencer for the single-port 128-word data memory. Port 0 serves the CPU load/store stage. Port 1 serves the OS context-save/restore engine. The block grants one requester at a time using round-robin, drives the memory's write-enable, address, write-data and read-strobe lines, and returns registered read data with a one-cycle acknowledge.

---
 rtl/arbitro_memdados_if.sv | 30 +++
 rtl/arbitro_memdados.sv | 86 ++++++++
 tb/tb_arbitro_memdados.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memdados_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// slave is the arbiter's view; master is the requester/memory side.
`timescale 1ns/1ps
interface arbitro_memdados_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          wr0, wr1;
  logic [AW-1:0] end0, end1;
  logic [DW-1:0] dado0, dado1;
  logic          ack0, ack1;
  logic [DW-1:0] leitura;
  logic          ocupado;
  logic          mem_escrita;
  logic          mem_ck;
  logic [AW-1:0] mem_endereco;
  logic [DW-1:0] mem_dado;
  logic [DW-1:0] mem_leitura;

  modport slave (
    input  req0, req1, wr0, wr1, end0, end1, dado0, dado1, mem_leitura,
    output ack0, ack1, leitura, ocupado, mem_escrita, mem_ck, mem_endereco, mem_dado
  );

  modport master (
    output req0, req1, wr0, wr1, end0, end1, dado0, dado1, mem_leitura,
    input  ack0, ack1, leitura, ocupado, mem_escrita, mem_ck, mem_endereco, mem_dado
  );
endinterface

// File: rtl/arbitro_memdados.sv
// Round-robin arbiter/sequencer giving the CPU (port 0) and the context-save engine
// (port 1) one-at-a-time access to the single-port 128-word data memory.
//
// state   | meaning
// OCIOSO  | idle, arbitrating between req0/req1
// ACESSO  | memory cycle: write-enable or read strobe from latched request
// ESPERA  | read only: memory data captured into leitura
// CONCLUI | ack pulse to the granted port, round-robin pointer updated
`timescale 1ns/1ps
module arbitro_memdados #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  arbitro_memdados_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, ACESSO, ESPERA, CONCLUI} estado_t;

  estado_t       estado, prox;
  logic          concede;
  logic          porta_nova;
  logic          porta;
  logic          ultimo;
  logic          wr_q;
  logic [AW-1:0] end_q;
  logic [DW-1:0] dado_q;
  logic [DW-1:0] leitura_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox       = estado;
    concede    = 1'b0;
    porta_nova = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.req0 || bus.req1) begin
          concede = 1'b1;
          // on a tie the port that was served last yields
          if (bus.req0 && bus.req1) porta_nova = ~ultimo;
          else                      porta_nova = bus.req1;
          prox = ACESSO;
        end
      end
      ACESSO:  prox = wr_q ? CONCLUI : ESPERA;
      ESPERA:  prox = CONCLUI;
      CONCLUI: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      porta     <= 1'b0;
      ultimo    <= 1'b1;
      wr_q      <= 1'b0;
      end_q     <= '0;
      dado_q    <= '0;
      leitura_q <= '0;
    end else begin
      if (concede) begin
        porta  <= porta_nova;
        wr_q   <= porta_nova ? bus.wr1   : bus.wr0;
        end_q  <= porta_nova ? bus.end1  : bus.end0;
        dado_q <= porta_nova ? bus.dado1 : bus.dado0;
      end
      if (estado == ESPERA)  leitura_q <= bus.mem_leitura;
      if (estado == CONCLUI) ultimo    <= porta;
    end
  end

  assign bus.mem_escrita  = (estado == ACESSO) &&  wr_q;
  assign bus.mem_ck       = (estado == ACESSO) && !wr_q;
  assign bus.mem_endereco = end_q;
  assign bus.mem_dado     = dado_q;
  assign bus.ack0         = (estado == CONCLUI) && !porta;
  assign bus.ack1         = (estado == CONCLUI) &&  porta;
  assign bus.ocupado      = (estado != OCIOSO);
  assign bus.leitura      = leitura_q;

endmodule

// File: tb/tb_arbitro_memdados.sv
// Randomized bench for arbitro_memdados against a transaction-level model:
// queued requests per port, round-robin service order, fixed latencies, shadow memory.
`timescale 1ns/1ps
module tb_arbitro_memdados;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic clk;
  logic reset;
  arbitro_memdados_if #(.AW(7), .DW(32)) bus();

  arbitro_memdados #(.AW(7), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // memory: write on clk while write-enabled, read data registered on the strobe
  logic [31:0] ram [128];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
    end else if (bus.mem_escrita) begin
      ram[bus.mem_endereco] <= bus.mem_dado;
    end
    if (bus.mem_ck) bus.mem_leitura <= ram[bus.mem_endereco];
  end

  // reference model state
  txn_t        fila [2][$];
  bit          pend [2];
  logic [31:0] shadow [128];
  logic [31:0] last_read;
  bit          last;
  bit          inflight;
  bit          win;
  logic        iw;
  logic [6:0]  ia;
  logic [31:0] id;
  int          t_grant, ack_at, free_at;
  bit          hold, scramble;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic enq(input int p, input logic w, input logic [6:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = w; t.addr = a; t.data = d;
    fila[p].push_back(t);
  endtask

  task automatic set_port(input bit p, input logic r, input logic w,
                          input logic [6:0] a, input logic [31:0] d);
    if (!p) begin
      bus.req0 = r; bus.wr0 = w; bus.end0 = a; bus.dado0 = d;
    end else begin
      bus.req1 = r; bus.wr1 = w; bus.end1 = a; bus.dado1 = d;
    end
  endtask

  task automatic observe();
    bit exp_ack;
    bit strobe;
    exp_ack = inflight && (cyc == ack_at);
    strobe  = inflight && (cyc == t_grant + 1);
    check("ack0",        32'(bus.ack0),        32'(exp_ack && !win));
    check("ack1",        32'(bus.ack1),        32'(exp_ack &&  win));
    check("ocupado",     32'(bus.ocupado),     32'(inflight));
    check("mem_escrita", 32'(bus.mem_escrita), 32'(strobe &&  iw));
    check("mem_ck",      32'(bus.mem_ck),      32'(strobe && !iw));
    if (inflight) check("mem_endereco", 32'(bus.mem_endereco), 32'(ia));
    if (strobe && iw) check("mem_dado", bus.mem_dado, id);
    if (exp_ack) begin
      if (iw) shadow[ia] = id;
      else    last_read  = shadow[ia];
      inflight = 1'b0;
      last     = win;
      free_at  = cyc + 1;
      pend[win] = 1'b0;
      void'(fila[win].pop_front());
    end
    check("leitura", bus.leitura, last_read);
  endtask

  task automatic drive_arb();
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && fila[p].size() > 0 && (hold || $urandom_range(0, 2) == 0)) pend[p] = 1'b1;
      if (pend[p]) set_port(p[0], 1'b1, fila[p][0].wr, fila[p][0].addr, fila[p][0].data);
      else         set_port(p[0], 1'b0, 1'($urandom), 7'($urandom), $urandom);
    end
    if (scramble && inflight) set_port(win, 1'b1, 1'($urandom), 7'($urandom), $urandom);
    if (!inflight && cyc >= free_at && (pend[0] || pend[1])) begin
      win      = (pend[0] && pend[1]) ? ~last : pend[1];
      iw       = fila[win][0].wr;
      ia       = fila[win][0].addr;
      id       = fila[win][0].data;
      t_grant  = cyc;
      ack_at   = cyc + (iw ? 2 : 3);
      inflight = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    observe();
    drive_arb();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (n < budget && (inflight || fila[0].size() > 0 || fila[1].size() > 0)) begin
      step();
      n++;
    end
    repeat (2) step();
  endtask

  // abandons any in-flight access; release happens on a negedge so the
  // following rising edge is the first arbitration
  task automatic apply_reset();
    reset = 1'b0;
    if (inflight) void'(fila[win].pop_front());
    inflight = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1'b1;
    last_read = '0;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      cyc++;
      observe();
    end
    @(negedge clk);
    cyc++;
    observe();
    reset = 1'b1;
    free_at = cyc;
    drive_arb();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int   k;
    reset = 1'b0;
    hold = 1'b1;
    scramble = 1'b0;
    inflight = 1'b0;
    free_at = 0;
    t_grant = 0;
    ack_at = 0;
    apply_reset();

    // tie straight after reset: port 0 first, then read both back
    enq(0, 1'b1, 7'd1, 32'h11);
    enq(1, 1'b1, 7'd2, 32'h22);
    run(40);
    enq(0, 1'b0, 7'd1, 32'h0);
    enq(1, 1'b0, 7'd2, 32'h0);
    run(40);

    enq(0, 1'b1, 7'd5, 32'hDEADBEEF);
    enq(0, 1'b0, 7'd5, 32'h0);
    run(40);

    // both held for 8 transactions: strict alternation
    for (int i = 0; i < 4; i++) begin
      enq(0, 1'($urandom), 7'($urandom_range(0, 15)), $urandom);
      enq(1, 1'($urandom), 7'($urandom_range(0, 15)), $urandom);
    end
    run(100);

    // granted port's inputs wander during the access
    scramble = 1'b1;
    enq(0, 1'b1, 7'd3, $urandom);
    enq(0, 1'b0, 7'd3, 32'h0);
    run(40);
    scramble = 1'b0;

    enq(0, 1'b1, 7'd7, 32'hA5A5A5A5);
    enq(0, 1'b0, 7'd7, 32'h0);
    enq(0, 1'b1, 7'd8, 32'h0);
    run(60);

    hold = 1'b0;
    scramble = 1'b1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 1);
      enq(k, 1'($urandom), 7'($urandom_range(0, 15)), $urandom);
    end
    run(3000);
    hold = 1'b1;
    scramble = 1'b0;

    // reset during ESPERA of a read
    enq(0, 1'b0, 7'd3, 32'h0);
    k = 0;
    while (k < 10 && !(inflight && cyc == t_grant + 2)) begin
      step();
      k++;
    end
    reset = 1'b0;
    #1;
    check("rst_ack0",        32'(bus.ack0),        32'h0);
    check("rst_ack1",        32'(bus.ack1),        32'h0);
    check("rst_ocupado",     32'(bus.ocupado),     32'h0);
    check("rst_mem_escrita", 32'(bus.mem_escrita), 32'h0);
    check("rst_mem_ck",      32'(bus.mem_ck),      32'h0);
    check("rst_mem_endereco",32'(bus.mem_endereco),32'h0);
    check("rst_mem_dado",    bus.mem_dado,         32'h0);
    check("rst_leitura",     bus.leitura,          32'h0);
    enq(1, 1'b1, 7'd20, 32'hCAFE0001);
    apply_reset();
    run(40);
    enq(0, 1'b1, 7'd21, 32'h0BAD0002);
    enq(1, 1'b0, 7'd20, 32'h0);
    run(40);
    enq(0, 1'b0, 7'd21, 32'h0);
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
